// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared types and constants for the text line overlay
package text_pkg;

    typedef enum logic [1:0] {
        CMD_WRITE     = 2'b00,
        CMD_BACKSPACE = 2'b01,
        CMD_CLEAR     = 2'b10,
        CMD_SETCUR    = 2'b11
    } cmd_op_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam int         GLYPH_W    = 5;
    localparam int         GLYPH_H    = 8;
    localparam int         CELL_W     = 6;

endpackage

// File: rtl/char_glyph_rom.sv
// rtl/char_glyph_rom.sv - combinational 5x8 glyph lookup, x=0 is the leftmost column
module char_glyph_rom (
    input  logic [7:0] code,
    input  logic [2:0] x,
    input  logic [2:0] y,
    output logic       pixel
);

    logic [39:0] w_glyph;
    logic [4:0]  w_row;
    logic [4:0]  w_sh;

    // Rows packed top (y=0) in the high bits; unknown codes render blank.
    always_comb begin
        w_glyph = '0;
        case (code)
            8'h30: w_glyph = {5'b01110, 5'b10001, 5'b10011, 5'b10101,
                              5'b11001, 5'b10001, 5'b01110, 5'b00000};
            8'h31: w_glyph = {5'b00100, 5'b01100, 5'b00100, 5'b00100,
                              5'b00100, 5'b00100, 5'b01110, 5'b00000};
            8'h41: w_glyph = {5'b01110, 5'b10001, 5'b10001, 5'b11111,
                              5'b10001, 5'b10001, 5'b10001, 5'b00000};
            default: w_glyph = '0;
        endcase
        w_row = 5'(w_glyph >> (6'd35 - 6'(y) * 6'd5));
        w_sh  = w_row << x;
        pixel = (x < 3'd5) && w_sh[4];
    end

endmodule

// File: rtl/text_line_ctrl.sv
// rtl/text_line_ctrl.sv - editable N-char text line with cursor; TEXT_CURSOR_BLINK_EN adds a blinking underline
module text_line_ctrl
    import text_pkg::*;
#(
    parameter int         N_CHARS      = 8,
    parameter int         SCALE_LOG2   = 2,
    parameter logic [8:0] X_LOC        = 9'd40,
    parameter logic [7:0] Y_LOC        = 8'd100,
    parameter int         BLINK_FRAMES = 30
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [8:0]                 hc_visible,
    input  logic [7:0]                 vc_visible,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [7:0]                 cmd_data,
    output logic [$clog2(N_CHARS)-1:0] cursor_pos,
    output logic                       busy,
    output logic                       in_square,
    output logic                       in_character
);

    localparam int CW    = $clog2(N_CHARS);
    localparam int SCALE = 1 << SCALE_LOG2;
    localparam logic [9:0] BX0 = 10'(X_LOC);
    localparam logic [9:0] BX1 = 10'(int'(X_LOC) + (CELL_W * N_CHARS + 2) * SCALE - 1);
    localparam logic [9:0] BY0 = 10'(Y_LOC);
    localparam logic [9:0] BY1 = 10'(int'(Y_LOC) + (GLYPH_H + 2) * SCALE - 1);
    localparam logic [9:0] TX0 = 10'(int'(X_LOC) + SCALE);
    localparam logic [9:0] TX1 = 10'(int'(X_LOC) + SCALE + CELL_W * N_CHARS * SCALE - 1);
    localparam logic [9:0] TY0 = 10'(int'(Y_LOC) + SCALE);
    localparam logic [9:0] TY1 = 10'(int'(Y_LOC) + SCALE + GLYPH_H * SCALE - 1);
    localparam logic [SCALE_LOG2-1:0] SUB_MAX = '1;

    state_t          r_state;
    logic [CW-1:0]   r_cursor;
    logic [CW-1:0]   r_idx;
    logic [7:0]      r_buf [N_CHARS];
    cmd_op_t         w_op;

    assign w_op       = cmd_op_t'(cmd_op);
    assign cmd_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state == ST_CLEAR);
    assign cursor_pos = r_cursor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cursor <= '0;
            r_idx    <= '0;
            for (int i = 0; i < N_CHARS; i++) r_buf[i] <= CHAR_SPACE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (w_op)
                            CMD_WRITE: begin
                                r_buf[r_cursor] <= cmd_data;
                                r_cursor        <= r_cursor + 1'b1;
                            end
                            CMD_BACKSPACE: begin
                                if (r_cursor != '0) begin
                                    r_cursor               <= r_cursor - 1'b1;
                                    r_buf[r_cursor - 1'b1] <= CHAR_SPACE;
                                end
                            end
                            CMD_CLEAR: begin
                                r_state <= ST_CLEAR;
                                r_idx   <= '0;
                            end
                            CMD_SETCUR: begin
                                r_cursor <= (cmd_data >= 8'(N_CHARS - 1)) ? CW'(N_CHARS - 1)
                                                                          : cmd_data[CW-1:0];
                            end
                        endcase
                    end
                end
                ST_CLEAR: begin
                    r_buf[r_idx] <= CHAR_SPACE;
                    r_idx        <= r_idx + 1'b1;
                    if (r_idx == CW'(N_CHARS - 1)) begin
                        r_cursor <= '0;
                        r_state  <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    logic [9:0]            w_hc;
    logic [9:0]            w_vc;
    logic                  w_box;
    logic                  w_in_text;
    logic [2:0]            w_row;
    logic                  w_pix;
    logic                  w_uline;
    logic [SCALE_LOG2-1:0] r_sub;
    logic [2:0]            r_col;
    logic [CW-1:0]         r_cell;

    assign w_hc      = {1'b0, hc_visible};
    assign w_vc      = {2'b0, vc_visible};
    assign w_box     = (w_hc >= BX0) && (w_hc <= BX1) && (w_vc >= BY0) && (w_vc <= BY1);
    assign w_in_text = (w_hc >= TX0) && (w_hc <= TX1) && (w_vc >= TY0) && (w_vc <= TY1);
    assign w_row     = 3'((w_vc - TY0) >> SCALE_LOG2);

    // Counters describe the pixel currently on hc_visible, so they step after it is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sub  <= '0;
            r_col  <= '0;
            r_cell <= '0;
        end else if (!w_in_text) begin
            r_sub  <= '0;
            r_col  <= '0;
            r_cell <= '0;
        end else if (r_sub == SUB_MAX) begin
            r_sub <= '0;
            if (r_col == 3'(CELL_W - 1)) begin
                r_col  <= '0;
                r_cell <= r_cell + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end else begin
            r_sub <= r_sub + 1'b1;
        end
    end

    char_glyph_rom u_rom (
        .code  (r_buf[r_cell]),
        .x     (r_col),
        .y     (w_row),
        .pixel (w_pix)
    );

`ifdef TEXT_CURSOR_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic          r_vc_nz;
    logic          r_blink;
    logic [FW-1:0] r_frame;
    logic          w_frame_tick;

    assign w_frame_tick = (vc_visible == 8'd0) && r_vc_nz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vc_nz <= 1'b0;
            r_blink <= 1'b0;
            r_frame <= '0;
        end else begin
            r_vc_nz <= (vc_visible != 8'd0);
            if (w_frame_tick) begin
                if (r_frame == FW'(BLINK_FRAMES - 1)) begin
                    r_frame <= '0;
                    r_blink <= ~r_blink;
                end else begin
                    r_frame <= r_frame + 1'b1;
                end
            end
        end
    end

    assign w_uline = r_blink && (w_row == 3'd7) && (r_cell == r_cursor) && (r_col < 3'(GLYPH_W));
`else
    assign w_uline = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_square    <= 1'b0;
            in_character <= 1'b0;
        end else begin
            in_square    <= w_box;
            in_character <= w_in_text && (w_pix || w_uline);
        end
    end

endmodule

// File: tb/tb_text_line_ctrl.sv
// tb/tb_text_line_ctrl.sv - directed self-checking bench for text_line_ctrl
module tb_text_line_ctrl;
    import text_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] hc_visible;
    logic [7:0] vc_visible;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic [2:0] cursor_pos;
    logic       busy;
    logic       in_square;
    logic       in_character;

    text_line_ctrl #(
        .N_CHARS      (8),
        .SCALE_LOG2   (2),
        .X_LOC        (9'd40),
        .Y_LOC        (8'd100),
        .BLINK_FRAMES (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hc_visible   (hc_visible),
        .vc_visible   (vc_visible),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .cursor_pos   (cursor_pos),
        .busy         (busy),
        .in_square    (in_square),
        .in_character (in_character)
    );

    always #5 clk = ~clk;

    int           n_cmp  = 0;
    int           n_fail = 0;
    logic [255:0] sq_v;
    logic [255:0] ch_v;
    logic [7:0]   bm [8];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output for hc=h is captured one edge after h was presented.
    task automatic scan_line(input logic [7:0] v);
        vc_visible = v;
        for (int h = 0; h < 256; h++) begin
            hc_visible = 9'(h);
            tick();
            sq_v[h] = in_square;
            ch_v[h] = in_character;
        end
        hc_visible = 9'd0;
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] d);
        int t;
        t         = 0;
        cmd_op    = op;
        cmd_data  = d;
        cmd_valid = 1'b1;
        while (!cmd_ready && t < 40) begin
            tick();
            t++;
        end
        if (!cmd_ready) check("send_ready_timeout", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
    endtask

    function automatic logic [255:0] box_vec(input int v);
        logic [255:0] r;
        r = '0;
        if (v >= 100 && v <= 139)
            for (int h = 40; h <= 239; h++) r[h] = 1'b1;
        return r;
    endfunction

    function automatic logic [4:0] row0_bits(input logic [7:0] c);
        case (c)
            8'h31:   return 5'b00100;
            8'h41:   return 5'b01110;
            default: return 5'b00000;
        endcase
    endfunction

    // Text origin hc=44, cell pitch 24, glyph column pitch 4.
    function automatic logic [255:0] text_row0();
        logic [255:0] r;
        logic [4:0]   b;
        r = '0;
        for (int c = 0; c < 8; c++) begin
            b = row0_bits(bm[c]);
            for (int k = 0; k < 5; k++)
                for (int s = 0; s < 4; s++)
                    if (b[4-k]) r[44 + c*24 + k*4 + s] = 1'b1;
        end
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lines [5];
        int           nb;
        int           nr;
        logic [2:0]   c8;
        logic [2:0]   c9;
        logic [255:0] ul;
        logic [255:0] exp_ul;

        lines = '{99, 100, 120, 139, 140};
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00;
        hc_visible = 9'd0; vc_visible = 8'd0;
        for (int i = 0; i < 8; i++) bm[i] = 8'h20;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_cursor", cursor_pos, 3'd0);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_square", in_square, 1'b0);
        check("rst_char", in_character, 1'b0);

        foreach (lines[i]) begin
            scan_line(8'(lines[i]));
            check($sformatf("box_sq_v%0d", lines[i]), sq_v, box_vec(lines[i]));
            check($sformatf("box_ch_v%0d", lines[i]), ch_v, '0);
        end

        for (int i = 0; i < 3; i++) begin
            send(CMD_WRITE, 8'h31);
            bm[i] = 8'h31;
        end
        check("write3_cursor", cursor_pos, 3'd3);
        scan_line(8'd104);
        check("write3_row0", ch_v, text_row0());

        send(CMD_SETCUR, 8'd200);
        check("setcur_clamp", cursor_pos, 3'd7);
        send(CMD_WRITE, 8'h41);
        bm[7] = 8'h41;
        check("write_wrap", cursor_pos, 3'd0);
        send(CMD_BACKSPACE, 8'h00);
        check("bksp_at0", cursor_pos, 3'd0);
        scan_line(8'd104);
        check("cell7_row0", ch_v, text_row0());

        send(CMD_SETCUR, 8'd3);
        send(CMD_BACKSPACE, 8'h00);
        bm[2] = 8'h20;
        check("bksp_cursor", cursor_pos, 3'd2);
        scan_line(8'd104);
        check("bksp_row0", ch_v, text_row0());

        cmd_op = CMD_CLEAR; cmd_data = 8'h00; cmd_valid = 1'b1;
        tick();
        cmd_op = CMD_SETCUR; cmd_data = 8'd5;
        nb = 0; nr = 0; c8 = 3'd7; c9 = 3'd7;
        for (int j = 0; j < 12; j++) begin
            if (busy) nb++;
            if (!cmd_ready) nr++;
            if (j == 8) c8 = cursor_pos;
            if (j == 9) c9 = cursor_pos;
            tick();
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) bm[i] = 8'h20;
        check("clear_busy_cycles", 32'(nb), 32'd8);
        check("clear_notready_cycles", 32'(nr), 32'd8);
        check("clear_cursor", c8, 3'd0);
        check("after_clear_accept", c9, 3'd5);
        scan_line(8'd104);
        check("clear_row0", ch_v, text_row0());

        send(CMD_WRITE, 8'h41);
        bm[5] = 8'h41;
        scan_line(8'd104);
        check("cell5_row0", ch_v, text_row0());
        cmd_op = CMD_CLEAR; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (3) tick();
        check("midclr_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midclr_rst_ready", cmd_ready, 1'b1);
        check("midclr_rst_busy", busy, 1'b0);
        check("midclr_rst_cursor", cursor_pos, 3'd0);
        #2 rst_n = 1'b1;
        tick();
        check("post_rst_ready", cmd_ready, 1'b1);
        check("post_rst_busy", busy, 1'b0);
        for (int i = 0; i < 8; i++) bm[i] = 8'h20;
        scan_line(8'd104);
        check("post_rst_row0", ch_v, text_row0());

        rst_n = 1'b0; vc_visible = 8'd0; hc_visible = 9'd0;
        tick();
        rst_n = 1'b1;
        tick();
        ul = '0;
        for (int h = 44; h < 64; h++) ul[h] = 1'b1;
        for (int f = 0; f < 6; f++) begin
            scan_line(8'd132);
`ifdef TEXT_CURSOR_BLINK_EN
            exp_ul = (f == 2 || f == 3) ? ul : '0;
`else
            exp_ul = '0;
`endif
            check($sformatf("underline_frame%0d", f), ch_v, exp_ul);
            vc_visible = 8'd0;
            hc_visible = 9'd0;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/text_line_ctrl.md
# text_line_ctrl

Controller for a single editable line of N characters on the VGA overlay. It holds a character buffer, modified through a valid/ready command port with cursor semantics. It scans the driver's visible-pixel counters and sequences the shared 5x8 glyph ROM one pixel per clock to produce box and foreground flags for the colour mux. It sits between the driver_vga counters and the pixel colour logic, alongside the existing single-character overlays.

## Interface
- N_CHARS, 8: characters in the line. Power of two, 2..16.
- SCALE_LOG2, 2: log2 of screen pixels per glyph pixel (SCALE = 1<<SCALE_LOG2).
- X_LOC, 9'd40: left edge of the box, in hc_visible units.
- Y_LOC, 8'd100: top edge of the box, in vc_visible units.
- BLINK_FRAMES, 30: frames per cursor blink half-period. Used only with the blink macro.

- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous reset, active-low.
- hc_visible  in  9  horizontal visible counter; advances by 1 per clk within a line.
- vc_visible  in  8  vertical visible counter.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  command: 00 WRITE, 01 BACKSPACE, 10 CLEAR, 11 SETCUR.
- cmd_data  in  8  ASCII code for WRITE; cursor index for SETCUR.
- cursor_pos  out  $clog2(N_CHARS)  current cursor cell.
- busy  out  1  high while CLEAR runs.
- in_square  out  1  registered; pixel lies inside the box (background).
- in_character  out  1  registered; pixel is glyph foreground.

## Operation
- Reset values:
  - buffer: all 8'h20.
  - cursor_pos: 0.
  - FSM: IDLE.
  - cmd_ready: 1.
  - busy: 0.
  - in_square and in_character: 0.
- Command FSM, IDLE:
  - cmd_ready = 1.
  - WRITE: buf[cursor] <= cmd_data; cursor <= cursor+1, wrapping N-1 -> 0.
  - BACKSPACE: if cursor == 0, no change. Otherwise cursor <= cursor-1 and buf[cursor-1] <= 8'h20.
  - SETCUR: cursor <= min(cmd_data, N-1).
  - CLEAR: go to CLEAR with sweep index 0.
- Command FSM, CLEAR:
  - cmd_ready = 0, busy = 1.
  - Writes 8'h20 to buf[idx], one entry per clock, for N clocks.
  - On the last entry: cursor <= 0, return to IDLE.
  - The next command can be accepted exactly N+1 cycles after CLEAR acceptance.
- A buffer write becomes visible on screen the clock after acceptance.
- Geometry:
  - Cell = 6 glyph columns (5 glyph + 1 gap) x 8 rows.
  - Box = one SCALE margin on every side.
  - Box width W = (6*N+2)*SCALE; box height H = 10*SCALE.
- Rendering:
  - in_square = 1 when hc in [X_LOC, X_LOC+W-1] and vc in [Y_LOC, Y_LOC+H-1].
  - Text area starts at (X_LOC+SCALE, Y_LOC+SCALE).
  - Glyph row = (vc-Y_LOC-SCALE) >> SCALE_LOG2.
  - Horizontal counters sub (0..SCALE-1), col (0..5), cell (0..N-1) are 0 when hc equals the text start and advance one step per clock. Each counter carries into the next.
  - Counters hold 0 outside the text area.
  - in_character = glyph(buf[cell], col, row) when inside the text area and col < 5; otherwise 0.
- Glyph ROM returns 0 for every unsupported code, including 8'h20.

## Timing
- in_square and in_character lag hc_visible/vc_visible by exactly 1 clk.
- Commands complete in 1 clk, except CLEAR, which takes N clks.
- cmd_ready is combinational from the FSM state only; it never depends on cmd_valid.
- A command issued during an active scan line is legal. Pixels after the update show the new character; no tearing protection is provided.
- Reset asserted mid-CLEAR: all state returns to reset values immediately. No partial sweep survives.

## Configuration
- TEXT_CURSOR_BLINK_EN defined:
  - Frame tick = first clk with vc_visible == 0 after a clk with vc_visible != 0.
  - Frame counter runs 0..BLINK_FRAMES-1; blink_phase toggles on wrap. Reset value is 0.
  - When blink_phase = 1, glyph row 7, cols 0..4 of cell cursor_pos force in_character = 1.
- Macro undefined: no frame counter, no cursor underline; BLINK_FRAMES is ignored.

## Structure
- Package text_pkg holds:
  - cmd_op_t enum (CMD_WRITE, CMD_BACKSPACE, CMD_CLEAR, CMD_SETCUR).
  - FSM state enum (ST_IDLE, ST_CLEAR).
  - Constants: CHAR_SPACE = 8'h20, GLYPH_W = 5, GLYPH_H = 8, CELL_W = 6.
- One sub-module, char_glyph_rom: combinational, inputs code[7:0], x[2:0], y[2:0], output pixel.

## Test plan
- Reset, then scan the full frame -> in_square high over the W x H box only; in_character always 0 (all spaces); cursor_pos = 0.
- WRITE 8'h31 three times -> cursor_pos = 3. Row 0 of cells 0..2 draws the '1' glyph; the gap column is never lit; output lags hc by 1 clk.
- With N = 8: SETCUR 200 -> cursor_pos = 7; WRITE 8'h41 -> buf[7] = 8'h41, cursor_pos wraps to 0. BACKSPACE at cursor 0 -> no change.
- CLEAR held with cmd_valid asserted -> cmd_ready low and busy high for exactly 8 clks. Buffer all 8'h20 and cursor_pos = 0 afterwards. rst_n pulse at sweep cycle 3 -> IDLE, cmd_ready = 1 next clk.
- TEXT_CURSOR_BLINK_EN, BLINK_FRAMES = 2 -> underline at the cursor cell visible in frames 2-3, absent in frames 0-1 and 4-5. Undefined build -> never visible.
